// File: rtl/name_entry_fsm_pkg.sv
// Shared constants and state type for the scoreboard name-entry controller.
package name_entry_fsm_pkg;

  localparam int unsigned CHAR_SIZE    = 5;
  localparam int unsigned BUTTON_COUNT = 4;
  localparam int unsigned TIMEOUT_W    = 8;

  localparam logic [CHAR_SIZE-1:0] CHAR_A     = 5'd0;
  localparam logic [CHAR_SIZE-1:0] CHAR_SPACE = 5'd26;

  // Bit positions inside btn = {right, left, down, up}
  localparam int unsigned BUTTON_UP    = 0;
  localparam int unsigned BUTTON_DOWN  = 1;
  localparam int unsigned BUTTON_LEFT  = 2;
  localparam int unsigned BUTTON_RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    DONE
  } name_entry_state_t;

endpackage

// File: rtl/name_entry_fsm_if.sv
// Event-pulse inputs and name/commit outputs of the name-entry controller.
interface name_entry_fsm_if
  import name_entry_fsm_pkg::*;
#(
  parameter int unsigned NAME_LEN  = 3,
  parameter int unsigned CHAR_BITS = CHAR_SIZE
);
  localparam int unsigned CUR_W = $clog2(NAME_LEN + 1);

  logic                          en;
  logic [BUTTON_COUNT-1:0]       btn;
  logic                          btn_other;
  logic                          tick_10hz;
  logic [NAME_LEN*CHAR_BITS-1:0] name_out;
  logic [CUR_W-1:0]              cursor;
  logic                          done;
  logic                          commit;
  logic [TIMEOUT_W-1:0]          timeout_left;

  modport master (
    output en, btn, btn_other, tick_10hz,
    input  name_out, cursor, done, commit, timeout_left
  );

  modport slave (
    input  en, btn, btn_other, tick_10hz,
    output name_out, cursor, done, commit, timeout_left
  );

endinterface

// File: rtl/name_entry_fsm_char_wheel.sv
// Combinational next-character for the selected slot; up has priority over down,
// both wrap between CHAR_MIN and CHAR_MAX.
module name_entry_fsm_char_wheel #(
  parameter int unsigned CHAR_BITS = 5,
  parameter int unsigned CHAR_MIN  = 0,
  parameter int unsigned CHAR_MAX  = 26
) (
  input  logic [CHAR_BITS-1:0] cur_char,
  input  logic                 up,
  input  logic                 down,
  output logic [CHAR_BITS-1:0] next_char
);
  localparam logic [CHAR_BITS-1:0] LO  = CHAR_BITS'(CHAR_MIN);
  localparam logic [CHAR_BITS-1:0] HI  = CHAR_BITS'(CHAR_MAX);
  localparam logic [CHAR_BITS-1:0] ONE = CHAR_BITS'(1);

  always_comb begin
    next_char = cur_char;
    if (up) begin
      next_char = (cur_char == HI) ? LO : cur_char + ONE;
    end else if (down) begin
      next_char = (cur_char == LO) ? HI : cur_char - ONE;
    end
  end

endmodule

// File: rtl/name_entry_fsm.sv
// Virtual-keyboard name entry: edits NAME_LEN chars from button pulses and strobes commit.
// Define NAME_ENTRY_TIMEOUT_EN to add the inactivity auto-commit counter.
module name_entry_fsm
  import name_entry_fsm_pkg::*;
#(
  parameter int unsigned NAME_LEN      = 3,
  parameter int unsigned CHAR_BITS     = CHAR_SIZE,
  parameter int unsigned CHAR_MIN      = CHAR_A,
  parameter int unsigned CHAR_MAX      = CHAR_SPACE,
  parameter int unsigned TIMEOUT_TICKS = 150
) (
  input logic            clk_main,
  input logic            rst,
  name_entry_fsm_if.slave bus
);
  localparam int unsigned CUR_W  = $clog2(NAME_LEN + 1);
  localparam int unsigned NAME_W = NAME_LEN * CHAR_BITS;

  localparam logic [CUR_W-1:0]     CONFIRM_SLOT   = CUR_W'(NAME_LEN);
  localparam logic [CUR_W-1:0]     CUR_ONE        = CUR_W'(1);
  localparam logic [CHAR_BITS-1:0] CHAR_FIRST     = CHAR_BITS'(CHAR_MIN);
  localparam logic [NAME_W-1:0]    IDLE_NAME      = {NAME_LEN{CHAR_FIRST}};
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_RELOAD = TIMEOUT_W'(TIMEOUT_TICKS);

  name_entry_state_t    state_q, state_n;
  logic [NAME_W-1:0]    name_q, name_n;
  logic [CUR_W-1:0]     cursor_q, cursor_n;
  logic                 done_q, done_n;
  logic                 commit_q, commit_n;
  logic                 do_commit;
  logic                 any_pulse;
  logic                 tmo_fire;
  logic [CHAR_BITS-1:0] cur_char, wheel_char;

  assign any_pulse = (|bus.btn) | bus.btn_other;

  // Character under the cursor; the confirm slot has none, so feed CHAR_MIN.
  always_comb begin
    cur_char = CHAR_FIRST;
    for (int unsigned i = 0; i < NAME_LEN; i++) begin
      if (cursor_q == CUR_W'(i)) begin
        cur_char = name_q[(NAME_LEN-1-i)*CHAR_BITS +: CHAR_BITS];
      end
    end
  end

  name_entry_fsm_char_wheel #(
    .CHAR_BITS (CHAR_BITS),
    .CHAR_MIN  (CHAR_MIN),
    .CHAR_MAX  (CHAR_MAX)
  ) u_char_wheel (
    .cur_char  (cur_char),
    .up        (bus.btn[BUTTON_UP]),
    .down      (bus.btn[BUTTON_DOWN]),
    .next_char (wheel_char)
  );

`ifdef NAME_ENTRY_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_n;

  // A button pulse reloads even when a tick lands in the same cycle.
  always_comb begin
    tmo_n    = tmo_q;
    tmo_fire = 1'b0;
    if (!bus.en || state_q == IDLE) begin
      tmo_n = TIMEOUT_RELOAD;
    end else if (state_q == EDIT) begin
      if (any_pulse) begin
        tmo_n = TIMEOUT_RELOAD;
      end else if (bus.tick_10hz && tmo_q != '0) begin
        tmo_n    = tmo_q - TIMEOUT_W'(1);
        tmo_fire = (tmo_q == TIMEOUT_W'(1));
      end
    end
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      tmo_q <= TIMEOUT_RELOAD;
    end else begin
      tmo_q <= tmo_n;
    end
  end

  assign bus.timeout_left = tmo_q;
`else
  assign tmo_fire         = 1'b0;
  assign bus.timeout_left = TIMEOUT_RELOAD;
`endif

  always_comb begin
    state_n   = state_q;
    name_n    = name_q;
    cursor_n  = cursor_q;
    done_n    = done_q;
    commit_n  = 1'b0;
    do_commit = 1'b0;

    unique case (state_q)
      IDLE: state_n = EDIT;
      EDIT: begin
        do_commit = tmo_fire;
        if (cursor_q != CONFIRM_SLOT) begin
          if (bus.btn[BUTTON_UP] || bus.btn[BUTTON_DOWN]) begin
            for (int unsigned i = 0; i < NAME_LEN; i++) begin
              if (cursor_q == CUR_W'(i)) begin
                name_n[(NAME_LEN-1-i)*CHAR_BITS +: CHAR_BITS] = wheel_char;
              end
            end
          end else if (bus.btn[BUTTON_LEFT]) begin
            cursor_n = (cursor_q == '0) ? CONFIRM_SLOT : cursor_q - CUR_ONE;
          end else if (bus.btn[BUTTON_RIGHT]) begin
            cursor_n = cursor_q + CUR_ONE;
          end
        end else if (bus.btn[BUTTON_LEFT]) begin
          cursor_n = cursor_q - CUR_ONE;
        end else if (any_pulse) begin
          do_commit = 1'b1;
        end

        if (do_commit) begin
          state_n  = DONE;
          done_n   = 1'b1;
          commit_n = 1'b1;
        end
      end
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase

    // Leaving the scoreboard scene wipes the entry regardless of state.
    if (!bus.en) begin
      state_n  = IDLE;
      name_n   = IDLE_NAME;
      cursor_n = '0;
      done_n   = 1'b0;
      commit_n = 1'b0;
    end
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      name_q   <= IDLE_NAME;
      cursor_q <= '0;
      done_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      name_q   <= name_n;
      cursor_q <= cursor_n;
      done_q   <= done_n;
      commit_q <= commit_n;
    end
  end

  assign bus.name_out = name_q;
  assign bus.cursor   = cursor_q;
  assign bus.done     = done_q;
  assign bus.commit   = commit_q;

endmodule
